// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive blocks: FSM states,
// Wishbone register offsets and status bit positions.
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    localparam logic [31:0] REG_DATA   = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;

    localparam int unsigned ST_VALID     = 0;
    localparam int unsigned ST_OVERRUN   = 1;
    localparam int unsigned ST_FRAME_ERR = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            q_o    <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/serialrx.sv
// Wishbone-attached UART receiver: mid-bit sampling, one-entry holding
// register, overrun and framing error flags with write-1-to-clear.
module serialrx
    import serial_pkg::*;
#(
    parameter int unsigned DIVIDE = 2,
    parameter int unsigned FRAME  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data_w,
    output logic [31:0] wb_data_r,
    input  logic        wb_we,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        wb_stall
);

    localparam int unsigned HALF = DIVIDE / 2;
    localparam int unsigned DW   = $clog2(DIVIDE);
    localparam int unsigned BW   = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic             rx_s;
    state_e           state_q;
    logic [DW-1:0]    div_q;
    logic [BW-1:0]    bit_q;
    logic [FRAME-1:0] shift_q;
    logic [FRAME-1:0] rx_data_q;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic        req, is_status, pop, clr_ovr, clr_fe;
    logic        stop_tick, store, set_ovr, set_fe;
    logic [31:0] rd_data;
    logic        unused_ok;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rx),
        .q_o (rx_s)
    );

    assign wb_stall  = 1'b0;
    assign unused_ok = ^{wb_addr[31:3], wb_addr[1:0], wb_data_w[31:3], wb_data_w[0]};

    assign req       = wb_cyc & wb_stb;
    assign is_status = (wb_addr[2] == REG_STATUS[2]);
    assign pop       = req & ~wb_we & ~is_status & rx_valid_q;
    assign clr_ovr   = req & wb_we & is_status & wb_data_w[ST_OVERRUN];
    assign clr_fe    = req & wb_we & is_status & wb_data_w[ST_FRAME_ERR];

    // A pop in the stop-sample cycle frees the holding register for the new byte.
    assign stop_tick = (state_q == S_STOP) && (div_q == DW'(DIVIDE - 1));
    assign store     = stop_tick & rx_s & (~rx_valid_q | pop);
    assign set_ovr   = stop_tick & rx_s & rx_valid_q & ~pop;
    assign set_fe    = stop_tick & ~rx_s;

    always_comb begin
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rd_data     = '0;
        if (store) begin
            rx_valid_d = 1'b1;
        end else if (pop) begin
            rx_valid_d = 1'b0;
        end
        // Setting wins over a simultaneous clear.
        overrun_d   = set_ovr | (overrun_q & ~clr_ovr);
        frame_err_d = set_fe | (frame_err_q & ~clr_fe);
        if (!wb_we) begin
            if (is_status) begin
                rd_data[ST_VALID]     = rx_valid_q;
                rd_data[ST_OVERRUN]   = overrun_q;
                rd_data[ST_FRAME_ERR] = frame_err_q;
            end else begin
                rd_data = 32'(rx_data_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wb_ack      <= 1'b0;
            wb_data_r   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        div_q   <= '0;
                    end
                end
                S_START: begin
                    if (div_q == DW'(HALF - 1)) begin
                        if (!rx_s) begin
                            state_q <= S_DATA;
                            div_q   <= '0;
                            bit_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_DATA: begin
                    if (div_q == DW'(DIVIDE - 1)) begin
                        shift_q[bit_q] <= rx_s;
                        div_q          <= '0;
                        if (bit_q == BW'(FRAME - 1)) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_STOP: begin
                    if (stop_tick) begin
                        state_q <= S_IDLE;
                        div_q   <= '0;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (store) begin
                rx_data_q <= shift_q;
            end
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;

            wb_ack <= req;
            if (req) begin
                wb_data_r <= rd_data;
            end
        end
    end

endmodule
